// File: rtl/exe_div_unit_if.sv
// Handshake and operand bundle between the EXE stage and the multi-cycle divider.
// The master side is the pipeline (EXE stage); the slave side is exe_div_unit.
interface exe_div_unit_if;
  logic        EXE_DivStart;
  logic        EXE_DivSigned;
  logic [31:0] EXE_OpA;
  logic [31:0] EXE_OpB;
  logic        EXE_DivAck;
  logic        EXE_DivFlush;
  logic        DIV_Busy;
  logic        DIV_Valid;
  logic [31:0] DIV_Quotient;
  logic [31:0] DIV_Remainder;

  modport master (
    output EXE_DivStart, EXE_DivSigned, EXE_OpA, EXE_OpB, EXE_DivAck, EXE_DivFlush,
    input  DIV_Busy, DIV_Valid, DIV_Quotient, DIV_Remainder
  );

  modport slave (
    input  EXE_DivStart, EXE_DivSigned, EXE_OpA, EXE_OpB, EXE_DivAck, EXE_DivFlush,
    output DIV_Busy, DIV_Valid, DIV_Quotient, DIV_Remainder
  );
endinterface

// File: rtl/exe_div_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the EXE stage; quotient -> LO, remainder -> HI.
// Optional macro DIV_ZERO_FAST_EN: a divide by zero skips the iterations and completes in one cycle.
//
// state | meaning
// IDLE  | waiting for a start request; outputs hold the last result
// BUSY  | one quotient bit resolved per cycle, 32 cycles
// DONE  | result valid, held until the pipeline acks
module exe_div_unit #(
  parameter int ITER_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  exe_div_unit_if.slave  div
);

  generate
    if (ITER_BITS != 1) begin : g_iter_bits_unsupported
      $error("exe_div_unit: only ITER_BITS = 1 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [5:0]  cnt_q;
  logic [63:0] prem_q;
  logic [31:0] dvsr_q;
  logic [31:0] quot_q;
  logic [31:0] rmdr_q;
  logic [31:0] raw_a_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;

  logic        load;
  logic        step;
  logic        finish;
`ifdef DIV_ZERO_FAST_EN
  logic        fast_dz;
`endif

  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        b_zero;

  logic [32:0] diff;
  logic [63:0] prem_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand conditioning at launch: magnitudes for signed ops, raw values otherwise.
  assign a_neg  = div.EXE_DivSigned & div.EXE_OpA[31];
  assign b_neg  = div.EXE_DivSigned & div.EXE_OpB[31];
  assign abs_a  = a_neg ? (~div.EXE_OpA + 32'd1) : div.EXE_OpA;
  assign abs_b  = b_neg ? (~div.EXE_OpB + 32'd1) : div.EXE_OpB;
  assign b_zero = (div.EXE_OpB == 32'd0);

  // Trial subtraction on the upper 33 bits of the partial remainder shifted left by one.
  assign diff     = prem_q[63:31] - {1'b0, dvsr_q};
  assign prem_nxt = diff[32] ? {prem_q[62:0], 1'b0}
                             : {diff[31:0], prem_q[30:0], 1'b1};

  // 0x80000000 / -1 needs no special case: the magnitude 0x80000000 negates to itself.
  assign q_fix = dz_q    ? 32'hFFFF_FFFF
               : q_neg_q ? (~prem_nxt[31:0] + 32'd1)
               :           prem_nxt[31:0];
  assign r_fix = dz_q    ? raw_a_q
               : r_neg_q ? (~prem_nxt[63:32] + 32'd1)
               :           prem_nxt[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast_dz = 1'b0;
`endif
    if (div.EXE_DivFlush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div.EXE_DivStart) begin
            load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
            if (b_zero) begin
              fast_dz = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
`else
            state_d = S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          step = 1'b1;
          if (cnt_q == 6'd1) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (div.EXE_DivAck) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 6'd0;
      prem_q  <= 64'd0;
      dvsr_q  <= 32'd0;
      quot_q  <= 32'd0;
      rmdr_q  <= 32'd0;
      raw_a_q <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (load) begin
        cnt_q   <= 6'd32;
        prem_q  <= {32'd0, abs_a};
        dvsr_q  <= abs_b;
        raw_a_q <= div.EXE_OpA;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        dz_q    <= b_zero;
      end
`ifdef DIV_ZERO_FAST_EN
      if (fast_dz) begin
        quot_q <= 32'hFFFF_FFFF;
        rmdr_q <= div.EXE_OpA;
      end
`endif
      if (step) begin
        prem_q <= prem_nxt;
        cnt_q  <= cnt_q - 6'd1;
      end
      if (finish) begin
        quot_q <= q_fix;
        rmdr_q <= r_fix;
      end
    end
  end

  // Busy is forced low while reset is asserted so the stall drops immediately.
  assign div.DIV_Busy      = rst & (((state_q == S_IDLE) & div.EXE_DivStart & ~div.EXE_DivFlush)
                                    | (state_q == S_BUSY));
  assign div.DIV_Valid     = (state_q == S_DONE);
  assign div.DIV_Quotient  = quot_q;
  assign div.DIV_Remainder = rmdr_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: directed corner cases plus randomized DIV/DIVU
// checked against a plain-arithmetic reference model.
module tb_exe_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_div_unit_if dif ();

  exe_div_unit #(.ITER_BITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .div (dif.slave)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic valid_d = 1'b0;
  logic [31:0] last_q = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural special cases.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sbv;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa  = $signed(a);
      sbv = $signed(b);
      q   = sa / sbv;
      r   = sa % sbv;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start in cycle 0 and queue the expected result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit push, output logic [31:0] eq, output logic [31:0] er);
    int lat;
    model(a, b, s, eq, er);
    lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) lat = 1;
`endif
    dif.EXE_OpA       = a;
    dif.EXE_OpB       = b;
    dif.EXE_DivSigned = s;
    dif.EXE_DivStart  = 1'b1;
    if (push) sb.push_back('{q: eq, r: er, t0: cyc, lat: lat});
    #1;
    chk("busy_cycle0", {31'd0, dif.DIV_Busy}, 32'd1);
  endtask

  task automatic finish_op(input int hold, input logic [31:0] eq, input logic [31:0] er);
    int n = 0;
    while (!dif.DIV_Valid && n < 40) begin
      step();
      n++;
    end
    if (!dif.DIV_Valid) chk("valid_timeout", {31'd0, dif.DIV_Valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'd0, dif.DIV_Valid}, 32'd1);
      chk("hold_busy", {31'd0, dif.DIV_Busy}, 32'd0);
      chk("hold_quot", dif.DIV_Quotient, eq);
      chk("hold_rem", dif.DIV_Remainder, er);
    end
    dif.EXE_DivAck   = 1'b1;
    dif.EXE_DivStart = 1'b0;
    step();
    dif.EXE_DivAck = 1'b0;
    chk("idle_after_ack_valid", {31'd0, dif.DIV_Valid}, 32'd0);
    chk("idle_after_ack_busy", {31'd0, dif.DIV_Busy}, 32'd0);
    last_q = eq;
  endtask

  // Monitor: compare on every rising edge of DIV_Valid.
  always @(negedge clk) begin
    if (rst && dif.DIV_Valid && !valid_d) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", dif.DIV_Quotient, mon_e.q);
        chk("remainder", dif.DIV_Remainder, mon_e.r);
        chk("latency", cyc - mon_e.t0, mon_e.lat);
        chk("busy_in_done", {31'd0, dif.DIV_Busy}, 32'd0);
      end
    end
    valid_d = dif.DIV_Valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] eq, er, a, b;
    logic        s;
    dif.EXE_DivStart  = 1'b0;
    dif.EXE_DivSigned = 1'b0;
    dif.EXE_OpA       = 32'd0;
    dif.EXE_OpB       = 32'd0;
    dif.EXE_DivAck    = 1'b0;
    dif.EXE_DivFlush  = 1'b0;
    #22;
    chk("rst_busy", {31'd0, dif.DIV_Busy}, 32'd0);
    chk("rst_valid", {31'd0, dif.DIV_Valid}, 32'd0);
    chk("rst_quot", dif.DIV_Quotient, 32'd0);
    chk("rst_rem", dif.DIV_Remainder, 32'd0);
    rst = 1'b1;
    step();

    // DIVU 100 / 7 with full busy profile
    launch(32'd100, 32'd7, 1'b0, 1'b1, eq, er);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("busy_profile", {31'd0, dif.DIV_Busy}, 32'd1);
      chk("busy_no_valid", {31'd0, dif.DIV_Valid}, 32'd0);
    end
    step();
    chk("cycle33_valid", {31'd0, dif.DIV_Valid}, 32'd1);
    chk("cycle33_quot", dif.DIV_Quotient, 32'd14);
    chk("cycle33_rem", dif.DIV_Remainder, 32'd2);
    finish_op(0, eq, er);

    launch(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, eq, er);
    finish_op(0, eq, er);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, eq, er);
    finish_op(0, eq, er);
    launch(32'h1234_5678, 32'd0, 1'b0, 1'b1, eq, er);
    finish_op(0, eq, er);
    launch(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1, eq, er);
    finish_op(0, eq, er);

    // Start held through DONE with ack withheld
    launch(32'd50, 32'hFFFF_FFFA, 1'b1, 1'b1, eq, er);
    finish_op(5, eq, er);

    // Flush in BUSY cycle 10
    launch(32'd1000, 32'd3, 1'b0, 1'b0, eq, er);
    repeat (10) step();
    dif.EXE_DivFlush = 1'b1;
    dif.EXE_DivStart = 1'b0;
    step();
    dif.EXE_DivFlush = 1'b0;
    chk("flush_busy", {31'd0, dif.DIV_Busy}, 32'd0);
    chk("flush_valid", {31'd0, dif.DIV_Valid}, 32'd0);
    chk("flush_hold_quot", dif.DIV_Quotient, last_q);
    repeat (40) step();
    launch(32'd9, 32'd3, 1'b0, 1'b1, eq, er);
    finish_op(0, eq, er);

    // Asynchronous reset in cycle 20
    launch(32'd77777, 32'd13, 1'b0, 1'b0, eq, er);
    repeat (20) step();
    #2;
    rst = 1'b0;
    dif.EXE_DivStart = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, dif.DIV_Busy}, 32'd0);
    chk("async_rst_valid", {31'd0, dif.DIV_Valid}, 32'd0);
    chk("async_rst_quot", dif.DIV_Quotient, 32'd0);
    chk("async_rst_rem", dif.DIV_Remainder, 32'd0);
    step();
    rst = 1'b1;
    step();
    launch(32'd12345, 32'd67, 1'b0, 1'b1, eq, er);
    finish_op(0, eq, er);

    // Randomized back-to-back operations
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (s && b != 32'd0 && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
      launch(a, b, s, 1'b1, eq, er);
      finish_op(0, eq, er);
    end

    repeat (5) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
